// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, result-source and forward selects.
// No logic beyond a small register-match helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // x0 is hard-wired, so a write to it never produces a value worth forwarding or waiting on.
    function automatic logic reg_hit(input logic [4:0] i_rd, input logic [4:0] i_rs);
        return (i_rd != REG_ZERO) && (i_rd == i_rs);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// E-stage operand forward select for one source register; M result beats W result.
// Purely combinational, zero latency, no backpressure.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rd_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_we_m,
    input  logic       i_we_w,
    output logic [1:0] o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (i_we_m && reg_hit(i_rd_m, i_rs)) begin
            o_sel = FWD_M;
        end else if (i_we_w && reg_hit(i_rd_w, i_rs)) begin
            o_sel = FWD_W;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/forward control: load-use, taken branch and memory-ready wait with timeout.
// Controls are combinational in the same cycle; a slow data memory freezes F..M and bubbles W.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    logic       w_mem_wait;
    logic       w_lw_stall;
    logic       w_to_hit;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    fwd_sel u_fwd_a (
        .i_rs   (Rs1E),
        .i_rd_m (RdM),
        .i_rd_w (RdW),
        .i_we_m (RegWriteM),
        .i_we_w (RegWriteW),
        .o_sel  (w_fwd_a)
    );

    fwd_sel u_fwd_b (
        .i_rs   (Rs2E),
        .i_rd_m (RdM),
        .i_rd_w (RdW),
        .i_we_m (RegWriteM),
        .i_we_w (RegWriteW),
        .o_sel  (w_fwd_b)
    );

    assign w_mem_wait = ((r_state == RUN) && MemReqM && !MemReadyM) ||
                        ((r_state == MEM_WAIT) && !MemReadyM);
    assign w_lw_stall = (ResultSrcE == RES_MEM) && (reg_hit(RdE, Rs1D) || reg_hit(RdE, Rs2D));
    assign w_to_hit   = (r_to_cnt == TO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:      if (MemReqM && !MemReadyM) w_state_nxt = MEM_WAIT;
            MEM_WAIT: begin
                if (MemReadyM)     w_state_nxt = RUN;
                else if (w_to_hit) w_state_nxt = ERROR;
            end
            ERROR:    w_state_nxt = ERROR;
            default:  w_state_nxt = RUN;
        endcase
    end

    // Outputs are forced low while reset_n is held so the pipeline sees no spurious stall or forward.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        mem_err   = 1'b0;
        if (reset_n) begin
            ForwardAE = w_fwd_a;
            ForwardBE = w_fwd_b;
            mem_err   = (r_state == ERROR);
            if ((r_state == ERROR) || w_mem_wait) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = w_lw_stall && !PCSrcE;
                StallD = w_lw_stall && !PCSrcE;
                FlushE = w_lw_stall || PCSrcE;
                FlushD = PCSrcE;
            end
        end
    end

    // Holding the count at zero in RUN clears it for every fresh entry into MEM_WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (r_state == MEM_WAIT) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (StallF && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (FlushD && (r_flush_events != '1)) r_flush_events <= r_flush_events + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl with a short timeout and narrow counters; expected outputs are queued
// at drive time and popped at the following negedge.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    localparam int TO = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic [1:0] rsrc;
        logic [4:0] rdm, rdw;
        logic       wm, ww, pc, req, rdy;
    } stim_t;

    typedef struct packed {
        logic          sf, sd, se, sm, fd, fe, fw;
        logic [1:0]    fa, fb;
        logic          err;
        logic [CW-1:0] sc, fev;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]    ResultSrcE;
    logic          RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] stall_cycles, flush_events;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    obs_t obs;
    assign obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                  ForwardAE, ForwardBE, mem_err, stall_cycles, flush_events};

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic stim_t S(int rs1d, int rs2d, int rs1e, int rs2e, int rde, int rsrc,
                                int rdm, int rdw, bit wm, bit ww, bit pc, bit req, bit rdy);
        stim_t s;
        s.rs1d = 5'(rs1d); s.rs2d = 5'(rs2d); s.rs1e = 5'(rs1e); s.rs2e = 5'(rs2e);
        s.rde  = 5'(rde);  s.rsrc = 2'(rsrc); s.rdm  = 5'(rdm);  s.rdw  = 5'(rdw);
        s.wm = wm; s.ww = ww; s.pc = pc; s.req = req; s.rdy = rdy;
        return s;
    endfunction

    function automatic obs_t E(bit sf, bit sd, bit se, bit sm, bit fd, bit fe, bit fw,
                               int fa, int fb, bit err, int sc, int fev);
        obs_t o;
        o.sf = sf; o.sd = sd; o.se = se; o.sm = sm; o.fd = fd; o.fe = fe; o.fw = fw;
        o.fa = 2'(fa); o.fb = 2'(fb); o.err = err; o.sc = CW'(sc); o.fev = CW'(fev);
        return o;
    endfunction

    task automatic drive(input stim_t s);
        Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e; RdE = s.rde;
        ResultSrcE = s.rsrc; RdM = s.rdm; RdW = s.rdw; RegWriteM = s.wm; RegWriteW = s.ww;
        PCSrcE = s.pc; MemReqM = s.req; MemReadyM = s.rdy;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        drive(S(0,0,0,0,0,0,0,0,0,0,0,0,0));
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t e;
        reset_n = 1'b0;
        drive(S(7,7,5,5,7,1,5,5,1,1,1,1,0));
        exp_q.push_back(E(0,0,0,0,0,0,0,0,0,0,0,0));
        #3;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL reset_hold got=%h exp=%h", obs, e); end
        apply_reset();
        exp_q.push_back(E(0,0,0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_forward();
        stim_t st[5];
        obs_t  ex[5];
        obs_t  e;
        apply_reset();
        st = '{S(0,0,5,0,0,0,5,5,1,1,0,0,0), S(0,0,5,0,0,0,5,5,0,1,0,0,0),
               S(0,0,0,5,0,0,5,5,0,1,0,0,0), S(0,0,0,5,0,0,5,5,1,1,0,0,0),
               S(0,0,3,3,0,0,0,3,1,1,0,0,0)};
        ex = '{E(0,0,0,0,0,0,0,2,0,0,0,0), E(0,0,0,0,0,0,0,1,0,0,0,0),
               E(0,0,0,0,0,0,0,0,1,0,0,0), E(0,0,0,0,0,0,0,0,2,0,0,0),
               E(0,0,0,0,0,0,0,1,1,0,0,0)};
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL forward[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t st[6];
        obs_t  ex[6];
        obs_t  e;
        apply_reset();
        st = '{S(0,7,0,0,7,1,0,0,0,0,0,0,0), S(0,0,0,0,0,0,0,0,0,0,0,0,0),
               S(0,0,0,0,0,1,0,0,0,0,0,0,0), S(7,0,0,0,7,0,0,0,0,0,0,0,0),
               S(7,0,0,0,7,2,0,0,0,0,0,0,0), S(7,0,0,0,7,1,0,0,0,0,0,0,0)};
        ex = '{E(1,1,0,0,0,1,0,0,0,0,0,0), E(0,0,0,0,0,0,0,0,0,0,1,0),
               E(0,0,0,0,0,0,0,0,0,0,1,0), E(0,0,0,0,0,0,0,0,0,0,1,0),
               E(0,0,0,0,0,0,0,0,0,0,1,0), E(1,1,0,0,0,1,0,0,0,0,1,0)};
        for (int i = 0; i < 6; i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL load_use[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        stim_t st[3];
        obs_t  ex[3];
        obs_t  e;
        apply_reset();
        st = '{S(0,7,0,0,7,1,0,0,0,0,1,0,0), S(0,0,0,0,0,0,0,0,0,0,1,0,0),
               S(0,0,0,0,0,0,0,0,0,0,0,0,0)};
        ex = '{E(0,0,0,0,1,1,0,0,0,0,0,0), E(0,0,0,0,1,1,0,0,0,0,0,1),
               E(0,0,0,0,0,0,0,0,0,0,0,2)};
        for (int i = 0; i < 3; i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL branch[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t st[5];
        obs_t  ex[5];
        obs_t  e;
        apply_reset();
        st = '{S(0,7,5,0,7,1,0,5,0,1,1,1,0), S(0,7,5,0,7,1,0,5,0,1,1,1,0),
               S(0,7,5,0,7,1,0,5,0,1,1,1,0), S(0,0,5,0,0,0,0,5,0,1,0,1,1),
               S(0,0,0,0,0,0,0,0,0,0,0,0,0)};
        ex = '{E(1,1,1,1,0,0,1,1,0,0,0,0), E(1,1,1,1,0,0,1,1,0,0,1,0),
               E(1,1,1,1,0,0,1,1,0,0,2,0), E(0,0,0,0,0,0,0,1,0,0,3,0),
               E(0,0,0,0,0,0,0,0,0,0,3,0)};
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL mem_wait[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout_edge();
        obs_t e;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 4)       drive(S(0,0,0,0,0,0,0,0,0,0,0,1,0));
            else if (i < 6)  drive(S(0,0,0,0,0,0,0,0,0,0,0,1,1));
            else             drive(S(0,0,0,0,0,0,0,0,0,0,0,0,0));
            if (i < 4) exp_q.push_back(E(1,1,1,1,0,0,1,0,0,0,i,0));
            else       exp_q.push_back(E(0,0,0,0,0,0,0,0,0,0,4,0));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL timeout_edge[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        obs_t e;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 5)       drive(S(0,0,0,0,0,0,0,0,0,0,0,1,0));
            else if (i == 5) drive(S(0,0,0,0,0,0,0,0,0,0,0,0,1));
            else             drive(S(0,0,0,0,0,0,0,0,0,0,1,0,1));
            exp_q.push_back(E(1,1,1,1,0,0,1,0,0,(i >= 5),i,0));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL timeout[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
        drive(S(7,7,5,5,7,1,5,5,1,1,1,1,0));
        #2;
        reset_n = 1'b0;
        exp_q.push_back(E(0,0,0,0,0,0,0,0,0,0,0,0));
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL err_async_reset got=%h exp=%h", obs, e); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                drive(S(0,0,0,0,0,0,0,0,0,0,0,0,0));
                exp_q.push_back(E(0,0,0,0,0,0,0,0,0,0,0,0));
            end else begin
                drive(S(0,0,5,0,0,0,5,0,1,0,0,0,0));
                exp_q.push_back(E(0,0,0,0,0,0,0,2,0,0,0,0));
            end
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL post_err_run[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturate();
        obs_t e;
        apply_reset();
        for (int i = 0; i < 41; i++) begin
            if (i < 20) begin
                drive(S(0,7,0,0,7,1,0,0,0,0,0,0,0));
                exp_q.push_back(E(1,1,0,0,0,1,0,0,0,0,(i > 15) ? 15 : i,0));
            end else if (i < 40) begin
                drive(S(0,0,0,0,0,0,0,0,0,0,1,0,0));
                exp_q.push_back(E(0,0,0,0,1,1,0,0,0,0,15,(i - 20 > 15) ? 15 : i - 20));
            end else begin
                drive(S(0,0,0,0,0,0,0,0,0,0,0,0,0));
                exp_q.push_back(E(0,0,0,0,0,0,0,0,0,0,15,15));
            end
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL saturate[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout_edge();
        test_timeout();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
